// File: rtl/mac_pkg.sv
// Shared types and constants for the 4x4 systolic MAC tile sequencer.
// Optional PERF_CYC counter is enabled by defining MAC_SEQ_PERF_EN.
package mac_pkg;

  localparam int ARR_DIM   = 4;
  localparam int BUF_DEPTH = 8;
  localparam int DATA_W    = 64;
  localparam int FLUSH_CYC = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_CLR   = 3'd2,
    S_FEED  = 3'd3,
    S_FLUSH = 3'd4,
    S_WRITE = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  function automatic logic [2:0] ceil_div4(input logic [3:0] v);
    logic [4:0] s;
    s = {1'b0, v} + 5'd3;
    return s[4:2];
  endfunction

  // A job is legal when every dimension fits the buffers: 1..BUF_DEPTH.
  function automatic logic mnt_legal(input logic [11:0] mnt);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (mnt[i*4 +: 4] == 4'd0 || mnt[i*4 +: 4] > 4'(BUF_DEPTH)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/mac_tile_sequencer_if.sv
// Control/data bundle between the tile sequencer (master) and the host/datapath (slave).
// PERF_CYC exists only when MAC_SEQ_PERF_EN is defined.
interface mac_tile_sequencer_if;
  import mac_pkg::*;

  // Job handshake: START is taken only while the sequencer is idle (MNT sampled with it);
  // BUSY covers the job, and exactly one of DONE or ERR pulses for one cycle to close it.
  logic [11:0]       MNT;
  logic              START;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic              EN_I;
  logic              EN_W;
  logic [2:0]        ADDR_I;
  logic [2:0]        ADDR_W;
  logic              ACC_CLR;
  logic              FEED_VLD;
  logic              TILE_M;
  logic              TILE_T;
  logic [1:0]        ROW_SEL;
  logic [DATA_W-1:0] RES_ROW;
  logic              EN_O;
  logic              RW_O;
  logic [3:0]        ADDR_O;
  logic [DATA_W-1:0] WDATA_O;
  state_t            STATE_DBG;
`ifdef MAC_SEQ_PERF_EN
  logic [15:0]       PERF_CYC;
`endif

  modport master (
    input  MNT, START, RES_ROW,
    output BUSY, DONE, ERR, EN_I, EN_W, ADDR_I, ADDR_W, ACC_CLR, FEED_VLD,
           TILE_M, TILE_T, ROW_SEL, EN_O, RW_O, ADDR_O, WDATA_O, STATE_DBG
`ifdef MAC_SEQ_PERF_EN
    , output PERF_CYC
`endif
  );

  modport slave (
    output MNT, START, RES_ROW,
    input  BUSY, DONE, ERR, EN_I, EN_W, ADDR_I, ADDR_W, ACC_CLR, FEED_VLD,
           TILE_M, TILE_T, ROW_SEL, EN_O, RW_O, ADDR_O, WDATA_O, STATE_DBG
`ifdef MAC_SEQ_PERF_EN
    , input PERF_CYC
`endif
  );

endinterface

// File: rtl/mac_seq_cnt.sv
// Loadable down-counter with terminal-count flag; stops at zero.
module mac_seq_cnt #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/mac_tile_sequencer.sv
// Tile sequencer for the 4x4 systolic MAC array: CHECK, then per tile CLR/FEED/FLUSH/WRITE.
// All outputs are registered from the next state. MAC_SEQ_PERF_EN adds the PERF_CYC counter.
module mac_tile_sequencer
  import mac_pkg::*;
(
  input logic                  CLK,
  input logic                  RST,
  mac_tile_sequencer_if.master bus
);

  state_t            state_q, state_d;
  logic [11:0]       mnt_q, mnt_d;
  logic              tile_m_q, tile_m_d, tile_t_q, tile_t_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              clr_q, clr_d, en_q, en_d, vld_q;
  logic [2:0]        addr_q, addr_d;
  logic [1:0]        row_sel_q, row_sel_d;
  logic              eno_q, eno_d;
  logic [3:0]        addro_q, addro_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [2:0] feed_cnt, flush_cnt, n_m1, tm_last, tt_last;
  logic [1:0] wr_cnt, cur_row, nxt_row;
  logic       feed_tc, flush_tc, wr_tc, last_m, last_t;
  logic [2:0] g_nxt;

  assign n_m1    = mnt_q[6:4] - 3'd1;
  assign tm_last = ceil_div4(mnt_q[11:8]) - 3'd1;
  assign tt_last = ceil_div4(mnt_q[3:0]) - 3'd1;
  assign last_m  = ({2'b00, tile_m_q} == tm_last);
  assign last_t  = ({2'b00, tile_t_q} == tt_last);
  assign cur_row = 2'(ARR_DIM - 1) - wr_cnt;

  mac_seq_cnt #(.W(3)) u_feed_cnt (
    .clk_i(CLK), .rst_i(RST), .load_i(state_q == S_CLR), .load_val_i(n_m1),
    .dec_i(state_q == S_FEED), .cnt_o(feed_cnt), .tc_o(feed_tc)
  );

  mac_seq_cnt #(.W(3)) u_flush_cnt (
    .clk_i(CLK), .rst_i(RST), .load_i(state_q == S_FEED), .load_val_i(3'(FLUSH_CYC - 1)),
    .dec_i(state_q == S_FLUSH), .cnt_o(flush_cnt), .tc_o(flush_tc)
  );

  mac_seq_cnt #(.W(2)) u_wr_cnt (
    .clk_i(CLK), .rst_i(RST), .load_i(state_q == S_FLUSH), .load_val_i(2'(ARR_DIM - 1)),
    .dec_i(state_q == S_WRITE), .cnt_o(wr_cnt), .tc_o(wr_tc)
  );

  always_comb begin
    state_d  = state_q;
    mnt_d    = mnt_q;
    tile_m_d = tile_m_q;
    tile_t_d = tile_t_q;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          mnt_d   = bus.MNT;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mnt_legal(mnt_q)) begin
          tile_m_d = 1'b0;
          tile_t_d = 1'b0;
          state_d  = S_CLR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR:   state_d = S_FEED;
      S_FEED:  if (feed_tc)  state_d = S_FLUSH;
      S_FLUSH: if (flush_tc) state_d = S_WRITE;
      S_WRITE: begin
        if (wr_tc) begin
          if (last_t && last_m) begin
            state_d = S_FIN;
          end else begin
            state_d = S_CLR;
            if (last_t) begin
              tile_t_d = 1'b0;
              tile_m_d = tile_m_q + 1'b1;
            end else begin
              tile_t_d = tile_t_q + 1'b1;
            end
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ROW_SEL runs one cycle ahead of the write beat, so WDATA_O can register RES_ROW
  // in the same edge that raises EN_O for that row.
  always_comb begin
    busy_d    = 1'b0;
    err_d     = 1'b0;
    done_d    = (state_d == S_FIN);
    clr_d     = (state_d == S_CLR);
    en_d      = (state_d == S_FEED);
    addr_d    = addr_q;
    row_sel_d = row_sel_q;
    eno_d     = 1'b0;
    addro_d   = addro_q;
    wdata_d   = wdata_q;
    nxt_row   = (state_q == S_WRITE) ? cur_row + 2'd1 : 2'd0;
    g_nxt     = {tile_m_q, nxt_row};

    case (state_d)
      S_CHECK: begin
        busy_d = mnt_legal(mnt_d);
        err_d  = !mnt_legal(mnt_d);
      end
      S_CLR, S_FEED, S_FLUSH, S_WRITE: busy_d = 1'b1;
      default: busy_d = 1'b0;
    endcase

    if (state_d == S_FEED) begin
      addr_d = (state_q == S_FEED) ? n_m1 - feed_cnt + 3'd1 : 3'd0;
    end

    if (state_d == S_WRITE) begin
      row_sel_d = (nxt_row == 2'd3) ? 2'd3 : nxt_row + 2'd1;
      eno_d     = ({1'b0, g_nxt} < mnt_q[11:8]);
      if (eno_d) begin
        addro_d = {g_nxt, tile_t_q};
        wdata_d = bus.RES_ROW;
      end
    end else if (state_q == S_FLUSH && flush_cnt == 3'd1) begin
      row_sel_d = 2'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      mnt_q     <= '0;
      tile_m_q  <= 1'b0;
      tile_t_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      clr_q     <= 1'b0;
      en_q      <= 1'b0;
      vld_q     <= 1'b0;
      addr_q    <= '0;
      row_sel_q <= '0;
      eno_q     <= 1'b0;
      addro_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      mnt_q     <= mnt_d;
      tile_m_q  <= tile_m_d;
      tile_t_q  <= tile_t_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      clr_q     <= clr_d;
      en_q      <= en_d;
      vld_q     <= en_q;
      addr_q    <= addr_d;
      row_sel_q <= row_sel_d;
      eno_q     <= eno_d;
      addro_q   <= addro_d;
      wdata_q   <= wdata_d;
    end
  end

`ifdef MAC_SEQ_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_q <= '0;
    end else if (state_q == S_IDLE && bus.START) begin
      perf_q <= '0;
    end else if (busy_q && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign bus.PERF_CYC = perf_q;
`endif

  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;
  assign bus.EN_I      = en_q;
  assign bus.EN_W      = en_q;
  assign bus.ADDR_I    = addr_q;
  assign bus.ADDR_W    = addr_q;
  assign bus.ACC_CLR   = clr_q;
  assign bus.FEED_VLD  = vld_q;
  assign bus.TILE_M    = tile_m_q;
  assign bus.TILE_T    = tile_t_q;
  assign bus.ROW_SEL   = row_sel_q;
  assign bus.EN_O      = eno_q;
  assign bus.RW_O      = eno_q;
  assign bus.ADDR_O    = addro_q;
  assign bus.WDATA_O   = wdata_q;
  assign bus.STATE_DBG = state_q;

endmodule

// File: tb/tb_mac_tile_sequencer.sv
// Directed bench for mac_tile_sequencer: tile walk, write addresses/data, timing, ERR, RST.
module tb_mac_tile_sequencer;
  import mac_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_fail   = 0;

  mac_tile_sequencer_if bus ();

  mac_tile_sequencer dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Array stand-in: the result row encodes which tile and row the sequencer selected.
  assign bus.RES_ROW = {48'hA5A5_5A5A_0F0F, 12'h000, bus.TILE_M, bus.TILE_T, bus.ROW_SEL};

  logic [67:0] exp_q[$];
  logic [67:0] obs_q[$];
  logic [2:0]  feed_q[$];
  int done_cyc, done_n, err_cyc, err_n, en_n, strobe_bad, vld_n, vld_first, en_first;
  int busy_n, busy_c1, clr_n;

  function automatic logic [67:0] exp_word(input logic tm, input logic tt, input logic [1:0] r);
    return {tm, r, tt, 48'hA5A5_5A5A_0F0F, 12'h000, tm, tt, r};
  endfunction

  function automatic logic [86:0] outs_vec();
    return {bus.BUSY, bus.DONE, bus.ERR, bus.EN_I, bus.EN_W, bus.ADDR_I, bus.ADDR_W,
            bus.ACC_CLR, bus.FEED_VLD, bus.TILE_M, bus.TILE_T, bus.ROW_SEL,
            bus.EN_O, bus.RW_O, bus.ADDR_O, bus.WDATA_O};
  endfunction

  task automatic build_exp(input int m, input int t);
    exp_q.delete();
    for (int tm = 0; tm < (m + 3) / 4; tm++)
      for (int tt = 0; tt < (t + 3) / 4; tt++)
        for (int r = 0; r < 4; r++)
          if (tm * 4 + r < m) exp_q.push_back(exp_word(tm[0], tt[0], r[1:0]));
  endtask

  task automatic run_job(input logic [11:0] mnt, input int cycles, input int alt_cyc,
                         input logic [11:0] alt_mnt);
    obs_q.delete();
    feed_q.delete();
    done_cyc = -1; done_n = 0; err_cyc = -1; err_n = 0; en_n = 0; strobe_bad = 0;
    vld_n = 0; vld_first = -1; en_first = -1; busy_n = 0; busy_c1 = -1; clr_n = 0;
    @(negedge CLK);
    bus.MNT   = mnt;
    bus.START = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= cycles; c++) begin
      @(negedge CLK);
      if (c == 1) busy_c1 = int'(bus.BUSY);
      if (bus.BUSY) busy_n++;
      if (bus.ACC_CLR) clr_n++;
      if (bus.DONE) begin done_n++; if (done_cyc < 0) done_cyc = c; end
      if (bus.ERR) begin err_n++; if (err_cyc < 0) err_cyc = c; end
      if (bus.EN_I) begin
        en_n++;
        if (en_first < 0) en_first = c;
        feed_q.push_back(bus.ADDR_I);
      end
      if (bus.FEED_VLD) begin vld_n++; if (vld_first < 0) vld_first = c; end
      if (bus.EN_I !== bus.EN_W || bus.ADDR_I !== bus.ADDR_W || bus.RW_O !== bus.EN_O)
        strobe_bad++;
      if (bus.EN_O) obs_q.push_back({bus.ADDR_O, bus.WDATA_O});
      bus.START = (c == alt_cyc);
      if (c == alt_cyc) bus.MNT = alt_mnt;
    end
    bus.START = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; bus.START = 1'b0; bus.MNT = 12'h000;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (outs_vec() !== 87'd0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", outs_vec()); end
    n_checks++;
    if (bus.STATE_DBG !== S_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", bus.STATE_DBG, S_IDLE); end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (outs_vec() !== 87'd0) begin n_fail++; $display("FAIL idle_outputs got=%h exp=0", outs_vec()); end
  endtask

  task automatic test_single_tile();
    build_exp(4, 4);
    run_job(12'h444, 20, -1, 12'h000);
    n_checks++;
    if (done_cyc !== 18) begin n_fail++; $display("FAIL t1_done_cycle got=%0d exp=18", done_cyc); end
    n_checks++;
    if (done_n !== 1) begin n_fail++; $display("FAIL t1_done_pulses got=%0d exp=1", done_n); end
    n_checks++;
    if (busy_c1 !== 1 || busy_n !== 17) begin n_fail++; $display("FAIL t1_busy got=%0d/%0d exp=1/17", busy_c1, busy_n); end
    n_checks++;
    if (clr_n !== 1) begin n_fail++; $display("FAIL t1_acc_clr got=%0d exp=1", clr_n); end
    n_checks++;
    if (en_first !== 3 || en_n !== 4) begin n_fail++; $display("FAIL t1_feed_en got=%0d/%0d exp=3/4", en_first, en_n); end
    n_checks++;
    if (vld_first !== 4 || vld_n !== 4) begin n_fail++; $display("FAIL t1_feed_vld got=%0d/%0d exp=4/4", vld_first, vld_n); end
    n_checks++;
    if (feed_q.size() !== 4) begin n_fail++; $display("FAIL t1_feed_len got=%0d exp=4", feed_q.size()); end
    for (int i = 0; i < feed_q.size() && i < 4; i++) begin
      n_checks++;
      if (feed_q[i] !== 3'(i)) begin n_fail++; $display("FAIL t1_feed_addr[%0d] got=%0d exp=%0d", i, feed_q[i], i); end
    end
    n_checks++;
    if (strobe_bad !== 0 || err_n !== 0) begin n_fail++; $display("FAIL t1_strobes got=%0d/%0d exp=0/0", strobe_bad, err_n); end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL t1_write_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t1_write[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_four_tiles();
    build_exp(8, 8);
    run_job(12'h888, 84, -1, 12'h000);
    n_checks++;
    if (done_cyc !== 82 || done_n !== 1) begin n_fail++; $display("FAIL t2_done got=%0d/%0d exp=82/1", done_cyc, done_n); end
    n_checks++;
    if (clr_n !== 4 || en_n !== 32 || busy_n !== 81) begin
      n_fail++; $display("FAIL t2_phase_counts got=%0d/%0d/%0d exp=4/32/81", clr_n, en_n, busy_n);
    end
    n_checks++;
    if (obs_q.size() !== 16) begin n_fail++; $display("FAIL t2_write_count got=%0d exp=16", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t2_write[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_partial_tiles();
    build_exp(3, 5);
    run_job(12'h325, 32, -1, 12'h000);
    n_checks++;
    if (done_cyc !== 30 || done_n !== 1) begin n_fail++; $display("FAIL t3_done got=%0d/%0d exp=30/1", done_cyc, done_n); end
    n_checks++;
    if (en_n !== 4 || clr_n !== 2) begin n_fail++; $display("FAIL t3_feed got=%0d/%0d exp=4/2", en_n, clr_n); end
    n_checks++;
    if (obs_q.size() !== 6) begin n_fail++; $display("FAIL t3_write_count got=%0d exp=6", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t3_write[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_illegal();
    logic [11:0] bad [2];
    bad[0] = 12'h048;
    bad[1] = 12'h948;
    for (int j = 0; j < 2; j++) begin
      run_job(bad[j], 8, -1, 12'h000);
      n_checks++;
      if (err_cyc !== 1 || err_n !== 1) begin n_fail++; $display("FAIL t4_err[%h] got=%0d/%0d exp=1/1", bad[j], err_cyc, err_n); end
      n_checks++;
      if (busy_n !== 0 || en_n !== 0 || obs_q.size() !== 0 || clr_n !== 0 || done_n !== 0) begin
        n_fail++; $display("FAIL t4_quiet[%h] got=%0d/%0d/%0d/%0d/%0d exp=0", bad[j], busy_n, en_n, obs_q.size(), clr_n, done_n);
      end
      n_checks++;
      if (bus.STATE_DBG !== S_IDLE) begin n_fail++; $display("FAIL t4_idle[%h] got=%0d exp=%0d", bad[j], bus.STATE_DBG, S_IDLE); end
    end
  endtask

  task automatic test_start_ignored();
    build_exp(4, 4);
    run_job(12'h444, 22, 4, 12'h888);
    n_checks++;
    if (done_cyc !== 18 || done_n !== 1 || busy_n !== 17) begin
      n_fail++; $display("FAIL t5_done got=%0d/%0d/%0d exp=18/1/17", done_cyc, done_n, busy_n);
    end
    n_checks++;
    if (en_n !== 4 || obs_q.size() !== 4) begin n_fail++; $display("FAIL t5_counts got=%0d/%0d exp=4/4", en_n, obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t5_write[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_job();
    int late_done;
    @(negedge CLK);
    bus.MNT   = 12'h444;
    bus.START = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      bus.START = 1'b0;
    end
    n_checks++;
    if (bus.EN_I !== 1'b1 || bus.ADDR_I !== 3'd2) begin
      n_fail++; $display("FAIL t6_third_feed got=%b/%0d exp=1/2", bus.EN_I, bus.ADDR_I);
    end
    RST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (outs_vec() !== 87'd0 || bus.STATE_DBG !== S_IDLE) begin
      n_fail++; $display("FAIL t6_reset_outputs got=%h exp=0", outs_vec());
    end
    RST = 1'b0;
    late_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (bus.DONE || bus.ERR || bus.BUSY) late_done++;
    end
    n_checks++;
    if (late_done !== 0) begin n_fail++; $display("FAIL t6_no_resume got=%0d exp=0", late_done); end
    build_exp(4, 4);
    run_job(12'h444, 20, -1, 12'h000);
    n_checks++;
    if (done_cyc !== 18 || obs_q.size() !== 4) begin
      n_fail++; $display("FAIL t6_rerun got=%0d/%0d exp=18/4", done_cyc, obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t6_write[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_four_tiles();
    test_partial_tiles();
    test_illegal();
    test_start_ignored();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
